ifu_fetch: RTL and testbench

Instruction fetch unit for the CPU datapath. It holds the program counter and fetches one instruction per step from instruction memory over a request/ready handshake. It presents the fetched word, and its imm16 field for the extend unit, to the decode/execute side over a valid/accept handshake. On accept it computes the next PC (sequential, branch or jump), using the 30-bit sign-extended branch offset returned by the extend unit.

---
 rtl/ifu_fetch_pkg.sv | 23 ++
 rtl/ifu_fetch_npc.sv | 34 +++
 rtl/ifu_fetch.sv | 94 +++++++++
 tb/tb_ifu_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings,
// the default reset PC and instruction field positions.
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    IFU_RST   = 2'b00,
    IFU_FETCH = 2'b01,
    IFU_HOLD  = 2'b10
  } ifu_state_e;

  // Byte address of the first instruction after reset (word aligned).
  localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;

  // Word-address PC width (byte PC without the two always-zero LSBs).
  localparam int PCW_W = 30;

  // Instruction field bit positions.
  localparam int IMM16_LSB = 0;
  localparam int IMM16_MSB = 15;
  localparam int TGT26_LSB = 0;
  localparam int TGT26_MSB = 25;

endpackage

// File: rtl/ifu_fetch_npc.sv
// Next-PC selection: jump target, taken branch or sequential word address.
// All arithmetic is on 30-bit word addresses and wraps modulo 2^30.
module npc_calc
  import ifu_fetch_pkg::*;
(
  input  logic [PCW_W-1:0]   pc_w,
  input  logic [TGT26_MSB:0] target26,
  input  logic [PCW_W-1:0]   br_offset,
  input  logic               branch,
  input  logic               zero,
  input  logic               jump,
  output logic [PCW_W-1:0]   npc
);

  logic        [PCW_W-1:0] pc1;
  logic signed [PCW_W-1:0] pc1_s;
  logic signed [PCW_W-1:0] off_s;
  logic signed [PCW_W-1:0] br_tgt_s;

  // Jump beats branch; a taken branch adds the signed word offset to pc+1.
  always_comb begin
    pc1      = pc_w + 30'd1;
    pc1_s    = signed'(pc1);
    off_s    = signed'(br_offset);
    br_tgt_s = pc1_s + off_s;
    npc      = pc1;
    if (jump) begin
      npc = {pc1[PCW_W-1:TGT26_MSB+1], target26};
    end else if (branch && zero) begin
      npc = unsigned'(br_tgt_s);
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, instruction register and a three-state
// FSM sequencing memory fetch (req/ready) and hand-off to decode (valid/accept).
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_accept,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [29:0] br_offset
);

  ifu_state_e       state_q, state_d;
  logic [PCW_W-1:0] pc_w_q, pc_w_d;
  logic [31:0]      instr_q, instr_d;
  logic [PCW_W-1:0] npc;

  npc_calc u_npc_calc (
    .pc_w      (pc_w_q),
    .target26  (instr_q[TGT26_MSB:TGT26_LSB]),
    .br_offset (br_offset),
    .branch    (branch),
    .zero      (zero),
    .jump      (jump),
    .npc       (npc)
  );

  // State, PC and instruction registers; reset drops any outstanding fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IFU_RST;
      pc_w_q  <= RESET_PC[31:2];
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_w_q  <= pc_w_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic: ready is only honoured in FETCH, accept only in HOLD,
  // so a continuously asserted accept still takes each instruction once.
  always_comb begin
    state_d = state_q;
    pc_w_d  = pc_w_q;
    instr_d = instr_q;
    case (state_q)
      IFU_RST: begin
        state_d = IFU_FETCH;
        pc_w_d  = RESET_PC[31:2];
      end
      IFU_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = IFU_HOLD;
        end
      end
      IFU_HOLD: begin
        if (instr_accept) begin
          pc_w_d  = npc;
          state_d = IFU_FETCH;
        end
      end
      default: begin
        state_d = IFU_RST;
      end
    endcase
  end

  // Handshake outputs are pure decodes of the state flop, so they are glitch
  // free and mutually exclusive.
  assign imem_req    = (state_q == IFU_FETCH);
  assign instr_valid = (state_q == IFU_HOLD);

  assign pc        = {pc_w_q, 2'b00};
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign instr     = instr_q;
  assign imm16     = instr_q[IMM16_MSB:IMM16_LSB];

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed, table-driven bench for ifu_fetch. Each table row is one clock
// cycle: inputs for that cycle plus the outputs expected during it.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [15:0] imm16;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_accept;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [29:0] br_offset;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .imm16        (imm16),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr_accept (instr_accept),
    .branch       (branch),
    .zero         (zero),
    .jump         (jump),
    .br_offset    (br_offset)
  );

  typedef struct {
    logic        rdy;
    logic        acc;
    logic        br;
    logic        zr;
    logic        jmp;
    logic [29:0] off;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic rdy, input logic acc, input logic br, input logic zr,
                   input logic jmp, input logic [29:0] off, input logic [31:0] rdata,
                   input logic e_req, input logic e_valid, input logic [31:0] e_pc,
                   input logic [31:0] e_instr);
    vec_t r;
    r.rdy = rdy; r.acc = acc; r.br = br; r.zr = zr; r.jmp = jmp; r.off = off;
    r.rdata = rdata; r.e_req = e_req; r.e_valid = e_valid; r.e_pc = e_pc;
    r.e_instr = e_instr;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
  endtask

  // Compare every observable output against one expected state.
  task automatic chk_all(input string tag, input int idx, input logic e_req,
                         input logic e_valid, input logic [31:0] e_pc,
                         input logic [31:0] e_instr);
    chk({tag, ".imem_req"},    idx, {31'd0, imem_req},    {31'd0, e_req});
    chk({tag, ".instr_valid"}, idx, {31'd0, instr_valid}, {31'd0, e_valid});
    chk({tag, ".imem_addr"},   idx, imem_addr, e_pc);
    chk({tag, ".pc"},          idx, pc,        e_pc);
    chk({tag, ".pc_plus4"},    idx, pc_plus4,  e_pc + 32'd4);
    chk({tag, ".instr"},       idx, instr,     e_instr);
    chk({tag, ".imm16"},       idx, {16'd0, imm16}, {16'd0, e_instr[15:0]});
  endtask

  task automatic drive(input logic rdy, input logic acc, input logic br, input logic zr,
                       input logic jmp, input logic [29:0] off, input logic [31:0] rdata);
    imem_ready = rdy; instr_accept = acc; branch = br; zero = zr; jump = jmp;
    br_offset = off; imem_rdata = rdata;
  endtask

  localparam logic [31:0] IA = 32'hA000_0001;
  localparam logic [31:0] IB = 32'hB000_0002;
  localparam logic [31:0] IC = 32'hC000_0003;
  localparam logic [31:0] ID = 32'hD000_1234;
  localparam logic [31:0] IE = 32'h1000_FFFE;
  localparam logic [31:0] IF = 32'h2000_0005;
  localparam logic [31:0] IG = 32'h3000_0006;
  localparam logic [31:0] IJ = 32'h0800_0100;
  localparam logic [31:0] IH = 32'h4000_0007;
  localparam logic [31:0] IK = 32'h5000_0008;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  localparam logic [29:0] M2 = 30'h3FFF_FFFE;

  initial begin
    //  rdy acc br zr jmp off   rdata  req val pc              instr
    // Zero-wait memory, accept held high throughout.
    v(1, 1, 0, 0, 0, 30'd0, IA,   1, 0, 32'h0000_3000, 32'h0);
    v(0, 1, 0, 0, 0, 30'd0, JUNK, 0, 1, 32'h0000_3000, IA);
    v(1, 1, 0, 0, 0, 30'd0, IB,   1, 0, 32'h0000_3004, IA);
    v(0, 1, 0, 0, 0, 30'd0, JUNK, 0, 1, 32'h0000_3004, IB);
    v(1, 1, 0, 0, 0, 30'd0, IC,   1, 0, 32'h0000_3008, IB);
    v(0, 1, 0, 0, 0, 30'd0, JUNK, 0, 1, 32'h0000_3008, IC);
    // Memory stalls 3 cycles at 0x300C; accept in FETCH is ignored.
    v(0, 1, 1, 1, 1, 30'd7, JUNK, 1, 0, 32'h0000_300C, IC);
    v(0, 0, 0, 0, 0, 30'd0, JUNK, 1, 0, 32'h0000_300C, IC);
    v(0, 0, 0, 0, 0, 30'd0, JUNK, 1, 0, 32'h0000_300C, IC);
    v(1, 0, 0, 0, 0, 30'd0, ID,   1, 0, 32'h0000_300C, IC);
    // Accept withheld 5 cycles; ready and branch controls ignored in HOLD.
    v(1, 0, 1, 1, 1, M2,    JUNK, 0, 1, 32'h0000_300C, ID);
    v(1, 0, 0, 0, 0, 30'd0, JUNK, 0, 1, 32'h0000_300C, ID);
    v(0, 0, 1, 1, 0, M2,    JUNK, 0, 1, 32'h0000_300C, ID);
    v(0, 0, 0, 0, 0, 30'd0, JUNK, 0, 1, 32'h0000_300C, ID);
    v(0, 0, 0, 0, 1, 30'd0, JUNK, 0, 1, 32'h0000_300C, ID);
    v(0, 1, 0, 0, 0, 30'd0, JUNK, 0, 1, 32'h0000_300C, ID);
    // Branch taken at 0x3010 with offset -2 -> 0x300C.
    v(1, 0, 0, 0, 0, 30'd0, IE,   1, 0, 32'h0000_3010, ID);
    v(0, 1, 1, 1, 0, M2,    JUNK, 0, 1, 32'h0000_3010, IE);
    v(1, 0, 0, 0, 0, 30'd0, IF,   1, 0, 32'h0000_300C, IE);
    v(0, 1, 0, 0, 0, 30'd0, JUNK, 0, 1, 32'h0000_300C, IF);
    // Branch not taken (zero=0) at 0x3010 -> 0x3014.
    v(1, 0, 0, 0, 0, 30'd0, IE,   1, 0, 32'h0000_3010, IF);
    v(0, 1, 1, 0, 0, M2,    JUNK, 0, 1, 32'h0000_3010, IE);
    // Jump with branch&zero also set: jump wins -> 0x400.
    v(1, 0, 0, 0, 0, 30'd0, IJ,   1, 0, 32'h0000_3014, IE);
    v(0, 1, 1, 1, 1, 30'd5, JUNK, 0, 1, 32'h0000_3014, IJ);
    v(1, 0, 0, 0, 0, 30'd0, IH,   1, 0, 32'h0000_0400, IJ);
    // Branch from word 0x100 to word 0x3FFF_FFFF, then sequential wrap to 0.
    v(0, 1, 1, 1, 0, 30'h3FFF_FEFE, JUNK, 0, 1, 32'h0000_0400, IH);
    v(1, 0, 0, 0, 0, 30'd0, IK,   1, 0, 32'hFFFF_FFFC, IH);
    v(0, 1, 0, 0, 0, 30'd0, JUNK, 0, 1, 32'hFFFF_FFFC, IK);
    v(0, 0, 0, 0, 0, 30'd0, JUNK, 1, 0, 32'h0000_0000, IK);
    v(0, 0, 0, 0, 0, 30'd0, JUNK, 1, 0, 32'h0000_0000, IK);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 30'd0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 0, 0, 0, 32'h0000_3000, 32'h0);
    // First cycle after reset release is still the reset state.
    rst = 1'b0;
    drive(1, 1, 0, 0, 0, 30'd0, JUNK);
    chk_all("rst_exit", 0, 0, 0, 32'h0000_3000, 32'h0);
    @(posedge clk);

    // Table-driven body.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rdy, vecs[i].acc, vecs[i].br, vecs[i].zr, vecs[i].jmp,
            vecs[i].off, vecs[i].rdata);
      chk_all("vec", i, vecs[i].e_req, vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr);
      @(posedge clk);
    end

    // Reset mid-FETCH (DUT now fetching at 0x0) with a late ready.
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 30'd0, JUNK);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 30'd0, 32'hBAD0_BAD0);
    chk_all("rst_fetch_a", 0, 0, 0, 32'h0000_3000, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 30'd0, JUNK);
    chk_all("rst_fetch_b", 0, 1, 0, 32'h0000_3000, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 30'd0, IA);
    chk_all("rst_fetch_c", 0, 1, 0, 32'h0000_3000, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 30'd0, JUNK);
    chk_all("rst_fetch_d", 0, 0, 1, 32'h0000_3000, IA);

    // Reset mid-HOLD with accept high: instruction is dropped, PC restored.
    rst = 1'b1;
    drive(0, 1, 0, 0, 1, 30'd0, JUNK);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 30'd0, JUNK);
    chk_all("rst_hold", 0, 0, 0, 32'h0000_3000, 32'h0);
    @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
